// File: rtl/im_boot_loader.sv
// Byte-stream program loader: parses SYNC,LEN,payload[,csum] frames, writes the payload into IM and holds the core until done.
// Optional checksum trailer and error state are enabled by defining IM_LOADER_CHECKSUM_EN.
module im_boot_loader #(
    parameter int                    IM_ADDR_W_m1 = 7,
    parameter int                    IM_DATA_W_m1 = 7,
    parameter logic [7:0]            SYNC_BYTE    = 8'hA5,
    parameter logic [IM_ADDR_W_m1:0] BASE_ADDR    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    restart,
    output logic                    im_we,
    output logic [IM_ADDR_W_m1:0]   im_addr,
    output logic [IM_DATA_W_m1:0]   im_wdata,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    err
);

    localparam logic [IM_ADDR_W_m1:0] ADDR_ONE  = 1;
    localparam logic [8:0]            COUNT_ONE = 9'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef IM_LOADER_CHECKSUM_EN
        ST_CSUM,
        ST_ERR,
`endif
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [8:0]              count_q, count_d;
    logic [IM_ADDR_W_m1:0]   ptr_q, ptr_d;
    logic                    im_we_q, im_we_d;
    logic [IM_ADDR_W_m1:0]   im_addr_q, im_addr_d;
    logic [IM_DATA_W_m1:0]   im_wdata_q, im_wdata_d;
    logic [IM_DATA_W_m1:0]   byte_data;
    logic                    accept;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]              sum_q, sum_d;
`endif

    // Stream bytes are truncated or zero-extended to the instruction width.
    generate
        if (IM_DATA_W_m1 < 8) begin : g_narrow
            assign byte_data = s_data[IM_DATA_W_m1:0];
        end else begin : g_wide
            assign byte_data = {{(IM_DATA_W_m1 - 7){1'b0}}, s_data};
        end
    endgenerate

    // restart has priority over a byte offered in the same cycle.
    always_comb begin
        s_ready = 1'b1;
        case (state_q)
            ST_DONE: s_ready = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            ST_ERR:  s_ready = ~restart;
`endif
            default: s_ready = 1'b1;
        endcase
    end

    assign accept = s_valid & s_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && s_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    count_d = (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
                    ptr_d   = BASE_ADDR;
`ifdef IM_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = ptr_q;
                    im_wdata_d = byte_data;
                    ptr_d      = ptr_q + ADDR_ONE;
                    count_d    = count_q - COUNT_ONE;
`ifdef IM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + s_data;
                    if (count_q == COUNT_ONE) begin
                        state_d = ST_CSUM;
                    end
`else
                    if (count_q == COUNT_ONE) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (s_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_ERR: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end else if (accept && s_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
`endif
            ST_DONE: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 9'd0;
            ptr_q      <= BASE_ADDR;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Hold drops on the same edge that registers the final write, so IM is updated before the first fetch.
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
`ifdef IM_LOADER_CHECKSUM_EN
    assign err      = (state_q == ST_ERR);
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_im_boot_loader.sv
// Scoreboard bench for im_boot_loader: expected IM writes are queued as bytes are sent; monitors pop on im_we.
// Two instances: default BASE_ADDR=0 and BASE_ADDR=F0 for the address wrap case.
module tb_im_boot_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       restart;
    int         sel;

    logic       s_valid0, s_valid1, restart0, restart1;
    logic       s_ready0, s_ready1;
    logic       im_we0, im_we1;
    logic [7:0] im_addr0, im_addr1, im_wdata0, im_wdata1;
    logic       cpu_hold0, cpu_hold1, done0, done1, err0, err1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    assign s_valid0 = s_valid && (sel == 0);
    assign s_valid1 = s_valid && (sel == 1);
    assign restart0 = restart && (sel == 0);
    assign restart1 = restart && (sel == 1);

    im_boot_loader u0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid0), .s_ready(s_ready0),
        .restart(restart0), .im_we(im_we0), .im_addr(im_addr0), .im_wdata(im_wdata0),
        .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    im_boot_loader #(.BASE_ADDR(8'hF0)) u1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid1), .s_ready(s_ready1),
        .restart(restart1), .im_we(im_we1), .im_addr(im_addr1), .im_wdata(im_wdata1),
        .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    always @(negedge clk) begin
        if (im_we0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL wr0_unexpected: got addr=%h data=%h, expected no write", im_addr0, im_wdata0);
            end else begin
                e0 = q0.pop_front();
                if (im_addr0 !== e0.a || im_wdata0 !== e0.d) begin
                    bad++;
                    $display("FAIL wr0: got (%h,%h) expected (%h,%h)", im_addr0, im_wdata0, e0.a, e0.d);
                end else begin
                    $display("wr0 ok (%h,%h)", im_addr0, im_wdata0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (im_we1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL wr1_unexpected: got addr=%h data=%h, expected no write", im_addr1, im_wdata1);
            end else begin
                e1 = q1.pop_front();
                if (im_addr1 !== e1.a || im_wdata1 !== e1.d) begin
                    bad++;
                    $display("FAIL wr1: got (%h,%h) expected (%h,%h)", im_addr1, im_wdata1, e1.a, e1.d);
                end else begin
                    $display("wr1 ok (%h,%h)", im_addr1, im_wdata1);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("chk %s ok (%h)", nm, act);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while ((((sel == 0) ? s_ready0 : s_ready1) !== 1'b1) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_ready=0 for 50 cycles, expected 1 (byte %h)", b);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end
    endtask

    task automatic data_byte(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        if (sel == 0) q0.push_back(w);
        else          q1.push_back(w);
        send_byte(d);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        restart = 1'b0;
        sel     = 0;
        tick(3);
        chk("rst_hold",   16'(cpu_hold0), 16'h1);
        chk("rst_done",   16'(done0),     16'h0);
        chk("rst_err",    16'(err0),      16'h0);
        chk("rst_we",     16'(im_we0),    16'h0);
        chk("rst_addr0",  16'(im_addr0),  16'h00);
        chk("rst_wdata",  16'(im_wdata0), 16'h00);
        chk("rst_addr1",  16'(im_addr1),  16'hF0);
        chk("rst_ready",  16'(s_ready0),  16'h1);
        rst_n = 1'b1;
        tick(2);

        // Basic 3-byte frame
        send_byte(8'hA5);
        send_byte(8'h03);
        data_byte(8'h00, 8'h11);
        data_byte(8'h01, 8'h22);
        data_byte(8'h02, 8'h33);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h66);
`endif
        chk("t1_done",  16'(done0),    16'h1);
        chk("t1_hold",  16'(cpu_hold0), 16'h0);
        chk("t1_ready", 16'(s_ready0), 16'h0);
        tick(2);
        pulse_restart();
        chk("t1_rst_done", 16'(done0),     16'h0);
        chk("t1_rst_hold", 16'(cpu_hold0), 16'h1);

        // Junk before sync is dropped
        send_byte(8'h7F);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h01);
        data_byte(8'h00, 8'h5C);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h5C);
`endif
        chk("t2_done", 16'(done0), 16'h1);
        tick(2);
        pulse_restart();

`ifdef IM_LOADER_CHECKSUM_EN
        // Bad checksum, then recovery from ERR
        send_byte(8'hA5);
        send_byte(8'h02);
        data_byte(8'h00, 8'h10);
        data_byte(8'h01, 8'h20);
        send_byte(8'h31);
        chk("t3_err",   16'(err0),      16'h1);
        chk("t3_hold",  16'(cpu_hold0), 16'h1);
        chk("t3_done",  16'(done0),     16'h0);
        chk("t3_ready", 16'(s_ready0),  16'h1);
        send_byte(8'hA5);
        send_byte(8'h01);
        data_byte(8'h00, 8'hAA);
        send_byte(8'hAA);
        chk("t3_err_clr", 16'(err0),  16'h0);
        chk("t3_done2",   16'(done0), 16'h1);
        tick(2);
        pulse_restart();
`endif

        // LEN=0 means 256 bytes
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            data_byte(8'(i), 8'(i));
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h80);
`endif
        chk("t4a_done", 16'(done0), 16'h1);
        tick(2);
        pulse_restart();

        // BASE_ADDR=F0 with 32 bytes wraps FF->00
        sel = 1;
        send_byte(8'hA5);
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            data_byte(8'hF0 + 8'(i), 8'(i + 1));
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h10);
`endif
        chk("t4b_done", 16'(done1),     16'h1);
        chk("t4b_hold", 16'(cpu_hold1), 16'h0);
        tick(2);
        pulse_restart();
        sel = 0;
        tick(1);

        // Async reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h04);
        data_byte(8'h00, 8'h01);
        data_byte(8'h01, 8'h02);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_we",    16'(im_we0),    16'h0);
        chk("t5_hold",  16'(cpu_hold0), 16'h1);
        chk("t5_addr",  16'(im_addr0),  16'h00);
        chk("t5_wdata", 16'(im_wdata0), 16'h00);
        chk("t5_done",  16'(done0),     16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        send_byte(8'hA5);
        send_byte(8'h01);
        data_byte(8'h00, 8'h77);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h77);
`endif
        chk("t5_reload_done", 16'(done0), 16'h1);
        tick(2);

        // restart beats a byte offered in DONE
        s_data  = 8'hA5;
        s_valid = 1'b1;
        restart = 1'b1;
        #1;
        chk("t6_ready_in_done", 16'(s_ready0), 16'h0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        s_valid = 1'b0;
        chk("t6_done",  16'(done0),     16'h0);
        chk("t6_hold",  16'(cpu_hold0), 16'h1);
        chk("t6_ready", 16'(s_ready0),  16'h1);
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h01);
        data_byte(8'h00, 8'h55);
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'h55);
`endif
        chk("t6_done2", 16'(done0), 16'h1);
        tick(3);

        chk("q0_empty", 16'(q0.size()), 16'h0);
        chk("q1_empty", 16'(q1.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
